// File: rtl/bike_pkg.sv
// Shared types and constants for the bike computer divider slice.
package bike_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  localparam logic CLIENT_SPEED = 1'b0;
  localparam logic CLIENT_AVG   = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_t;

  function automatic logic [1:0] client_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/div_rr_arbiter.sv
// Two-client round-robin arbiter: pending flags, last-winner register, grant decode.
module div_rr_arbiter
  import bike_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       gnt_en_i,
  output logic       gnt_valid_c_o,
  output logic       gnt_idx_c_o
);

  logic [1:0] pend_q, pend_d;
  logic       last_q, last_d;
  logic [1:0] clr_c;

  // A new request on the grant edge re-arms the slot (set beats clear).
  always_comb begin
    gnt_valid_c_o = 1'b0;
    gnt_idx_c_o   = CLIENT_SPEED;
    clr_c         = 2'b00;
    last_d        = last_q;

    if (pend_q == 2'b11) begin
      gnt_idx_c_o = ~last_q;
    end else begin
      gnt_idx_c_o = pend_q[1];
    end

    gnt_valid_c_o = gnt_en_i && (pend_q != 2'b00);
    if (gnt_valid_c_o) begin
      clr_c  = client_onehot(gnt_idx_c_o);
      last_d = gnt_idx_c_o;
    end

    pend_d = (pend_q & ~clr_c) | req_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 2'b00;
      last_q <= CLIENT_AVG;
    end else begin
      pend_q <= pend_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/shared_divider.sv
// Restoring radix-2 divider shared by the speed and average-speed clients.
// Remainder output exists only when SHARED_DIVIDER_REMAINDER_EN is defined.
module shared_divider
  import bike_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start0,
  input  logic             start1,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] divisor0,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor1,
  output logic             busy,
  output logic             ready,
  output logic             select,
  output logic [WIDTH-1:0] quotient,
`ifdef SHARED_DIVIDER_REMAINDER_EN
  output logic [WIDTH-1:0] remainder,
`endif
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  div_state_t state_q;

  logic [1:0][WIDTH-1:0] op_dvd_q;
  logic [1:0][WIDTH-1:0] op_dvs_q;

  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q;
  logic             zero_q;

  logic             gnt_en_c;
  logic             gnt_valid_c;
  logic             gnt_idx_c;
  logic [WIDTH-1:0] gnt_dvd_c;
  logic [WIDTH-1:0] gnt_dvs_c;
  logic [WIDTH:0]   partial_c;
  logic             ge_c;

  // Hold off grants during the ready cycle so every result gets a full IDLE cycle.
  assign gnt_en_c = (state_q == IDLE) && !ready;

  div_rr_arbiter u_arb (
    .clk           (clk),
    .rst           (rst),
    .req_i         ({start1, start0}),
    .gnt_en_i      (gnt_en_c),
    .gnt_valid_c_o (gnt_valid_c),
    .gnt_idx_c_o   (gnt_idx_c)
  );

  // Latest request per client wins; operands captured only on start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_dvd_q <= '0;
      op_dvs_q <= '0;
    end else begin
      if (start0) begin
        op_dvd_q[0] <= dividend0;
        op_dvs_q[0] <= divisor0;
      end
      if (start1) begin
        op_dvd_q[1] <= dividend1;
        op_dvs_q[1] <= divisor1;
      end
    end
  end

  // One restoring step: extra partial-remainder bit keeps the compare exact.
  always_comb begin
    gnt_dvd_c = op_dvd_q[gnt_idx_c];
    gnt_dvs_c = op_dvs_q[gnt_idx_c];
    partial_c = {rem_q, dvd_q[WIDTH-1]};
    ge_c      = partial_c >= {1'b0, dvs_q};
    rem_d     = partial_c[WIDTH-1:0];
    if (ge_c) begin
      rem_d = WIDTH'(partial_c - {1'b0, dvs_q});
    end
    dvd_d = {dvd_q[WIDTH-2:0], ge_c};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      select    <= CLIENT_SPEED;
      quotient  <= '0;
      div_zero  <= 1'b0;
`ifdef SHARED_DIVIDER_REMAINDER_EN
      remainder <= '0;
`endif
    end else begin
      ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid_c) begin
            select  <= gnt_idx_c;
            dvd_q   <= gnt_dvd_c;
            dvs_q   <= gnt_dvs_c;
            rem_q   <= '0;
            zero_q  <= (gnt_dvs_c == '0);
            cnt_q   <= (gnt_dvs_c == '0) ? CW'(1) : CW'(WIDTH);
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!zero_q) begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
          end
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quotient  <= zero_q ? '1 : dvd_d;
            div_zero  <= zero_q;
`ifdef SHARED_DIVIDER_REMAINDER_EN
            remainder <= zero_q ? dvd_q : rem_d;
`endif
            ready     <= 1'b1;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_divider.sv
// Scoreboard bench for shared_divider: directed cases plus randomized traffic.
module tb_shared_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] dividend0 = '0, divisor0 = '0, dividend1 = '0, divisor1 = '0;
  logic        busy, ready, select, div_zero;
  logic [15:0] quotient;
`ifdef SHARED_DIVIDER_REMAINDER_EN
  logic [15:0] remainder;
`endif

  typedef struct {
    bit          sel;
    logic [15:0] q;
    logic [15:0] r;
    bit          dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   model_last = 1'b1;

  shared_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start0    (start0),
    .start1    (start1),
    .dividend0 (dividend0),
    .divisor0  (divisor0),
    .dividend1 (dividend1),
    .divisor1  (divisor1),
    .busy      (busy),
    .ready     (ready),
    .select    (select),
    .quotient  (quotient),
`ifdef SHARED_DIVIDER_REMAINDER_EN
    .remainder (remainder),
`endif
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain unsigned division with saturation on zero divisor.
  function automatic exp_t model(input bit sel, input logic [15:0] a, input logic [15:0] b, input int c);
    exp_t e;
    e.sel = sel;
    e.dz  = (b == 16'd0);
    e.q   = e.dz ? 16'hFFFF : a / b;
    e.r   = e.dz ? a : a % b;
    e.cyc = c;
    return e;
  endfunction

  function automatic int lat(input logic [15:0] b);
    return (b == 16'd0) ? 2 : 17;
  endfunction

  // Pulse starts for one cycle; t0 is the cycle count of the sampling edge.
  task automatic issue(input bit s0, input bit s1, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1, output int t0);
    @(negedge clk);
    start0 = s0; start1 = s1;
    dividend0 = a0; divisor0 = b0; dividend1 = a1; divisor1 = b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    t0 = cyc;
  endtask

  task automatic run_single(input bit c, input logic [15:0] a, input logic [15:0] b);
    int t0;
    if (c) issue(1'b0, 1'b1, 16'd0, 16'd0, a, b, t0);
    else   issue(1'b1, 1'b0, a, b, 16'd0, 16'd0, t0);
    sb.push_back(model(c, a, b, t0 + lat(b)));
    model_last = c;
  endtask

  task automatic run_both(input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1);
    int t0, first_cyc;
    bit w;
    issue(1'b1, 1'b1, a0, b0, a1, b1, t0);
    w = ~model_last;
    first_cyc = t0 + (w ? lat(b1) : lat(b0));
    if (w) begin
      sb.push_back(model(1'b1, a1, b1, first_cyc));
      sb.push_back(model(1'b0, a0, b0, first_cyc + 1 + lat(b0)));
    end else begin
      sb.push_back(model(1'b0, a0, b0, first_cyc));
      sb.push_back(model(1'b1, a1, b1, first_cyc + 1 + lat(b1)));
    end
    model_last = ~w;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_select"}, 32'(select), 32'd0);
    check({tag, "_quotient"}, 32'(quotient), 32'd0);
    check({tag, "_div_zero"}, 32'(div_zero), 32'd0);
`ifdef SHARED_DIVIDER_REMAINDER_EN
    check({tag, "_remainder"}, 32'(remainder), 32'd0);
`endif
  endtask

  // Monitor: every ready pops the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: ready=1 with nothing outstanding, required ready=0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("select", 32'(select), 32'(e.sel));
          check("quotient", 32'(quotient), 32'(e.q));
          check("div_zero", 32'(div_zero), 32'(e.dz));
`ifdef SHARED_DIVIDER_REMAINDER_EN
          check("remainder", 32'(remainder), 32'(e.r));
`endif
          check("ready_cycle", 32'(cyc), 32'(e.cyc));
          check("busy_with_ready", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [15:0] a, b, a1, b1;
    int sel;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset");

    run_single(1'b0, 16'd1000, 16'd7);
    drain();
    run_single(1'b1, 16'd65535, 16'd1);
    drain();
    run_single(1'b1, 16'd5, 16'd9);
    drain();
    run_single(1'b0, 16'd1234, 16'd0);
    drain();
    run_single(1'b0, 16'd1000, 16'd7);
    drain();

    do_reset();
    run_both(16'd36000, 16'd600, 16'd7200, 16'd20);
    drain();

    // Client 1 overwrites its pending request while client 0 is in flight.
    issue(1'b1, 1'b0, 16'd4000, 16'd9, 16'd0, 16'd0, t0);
    sb.push_back(model(1'b0, 16'd4000, 16'd9, t0 + 17));
    repeat (2) @(negedge clk);
    issue(1'b0, 1'b1, 16'd0, 16'd0, 16'd100, 16'd3, sel);
    repeat (2) @(negedge clk);
    issue(1'b0, 1'b1, 16'd0, 16'd0, 16'd200, 16'd3, sel);
    sb.push_back(model(1'b1, 16'd200, 16'd3, t0 + 35));
    model_last = 1'b1;
    drain();

    // Reset in the middle of a division discards it.
    issue(1'b1, 1'b0, 16'd5000, 16'd13, 16'd0, 16'd0, t0);
    repeat (5) @(negedge clk);
    check("busy_mid_run", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check_outputs_zero("post_reset");
    run_single(1'b0, 16'd5000, 16'd13);
    drain();

    for (int i = 0; i < 40; i++) begin
      a  = 16'($urandom_range(0, 65535));
      a1 = 16'($urandom_range(0, 65535));
      sel = $urandom_range(0, 9);
      b  = (sel == 0) ? 16'd0 : (sel < 4) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      sel = $urandom_range(0, 9);
      b1 = (sel == 0) ? 16'd0 : (sel < 4) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      if ($urandom_range(0, 1) == 0) run_single(1'($urandom_range(0, 1)), a, b);
      else                           run_both(a, b, a1, b1);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
